normalize_round_mult_pipe: RTL
==============================

# normalize_round_mult_pipe

Pipelined normalize-and-round back end for the parametrised floating-point multiplier. It takes the raw double-width significand product and the pre-normalisation exponent, normalises by 0 or 1 position, and rounds to one of four IEEE-754 rounding modes. It then resolves overflow and underflow (flush-to-zero) and emits packed sign/exponent/mantissa with exception flags. It sits between the significand multiplier array and the result mux, behind a valid/ready handshake, so upstream multiplier stages can be back-pressured.

## Interface
- sig_width, 23, stored mantissa bits (hidden bit excluded)
- ex_width, 8, stored exponent bits
- clk  in  1  sole clock, rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- in_valid  in  1  input transaction present
- in_ready  out  1  block accepts input this cycle
- in_sign  in  1  product sign
- in_zero  in  1  product is exact zero; mant_mult/exp_sub ignored
- mant_mult  in  2*sig_width+2  unsigned product of two (sig_width+1)-bit significands with hidden bits
- exp_sub  in  ex_width+2  two's-complement biased exponent sum minus bias
- rnd_mode  in  2  00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_sign  out  1  result sign
- out_exp  out  ex_width  biased result exponent
- out_mant  out  sig_width  stored result mantissa
- out_overflow, out_underflow, out_inexact  out  1 each  exception flags, qualified by out_valid

## Operation
- Operands reaching this block are finite. Inf/NaN bypass it in the datapath.
- Stage 1 (normalise), registered:
  - If mant_mult[2*sig_width+1]=1: exp = exp_sub+1, mant = mant_mult[2*sig_width:sig_width+1], g = mant_mult[sig_width], s = |mant_mult[sig_width-1:0].
  - Else: exp = exp_sub, mant = mant_mult[2*sig_width-1:sig_width], g = mant_mult[sig_width-1], s = |mant_mult[sig_width-2:0].
  - Register sign, zero and rnd_mode with the data.
- Stage 2 (round/resolve), registered:
  - Increment condition:
    - RNE: g&(s|mant[0]).
    - RTZ: never.
    - RUP: (g|s)&~sign.
    - RDN: (g|s)&sign.
  - If the increment carries out of mant, mant becomes 0 and exp+1.
  - Compare exp signed, at ex_width+2 bits, after rounding.
- Overflow, when exp >= 2^ex_width-1:
  - Sets out_overflow=1 and out_inexact=1.
  - Result is inf (exp all ones, mant 0) for RNE, for RUP with sign=0, and for RDN with sign=1.
  - Otherwise the result is max finite (exp 2^ex_width-2, mant all ones).
- Underflow, when exp <= 0:
  - Result is signed zero (exp 0, mant 0), with out_underflow=1 and out_inexact=1.
  - No subnormal output.
- Otherwise out_inexact = g|s.
- When in_zero=1 the result is signed zero with all flags 0 and rnd_mode ignored.

## Timing
- Latency: 2 cycles from the accepting edge (in_valid&in_ready) to out_valid.
- Throughput: 1 transaction per cycle while out_ready=1.
- Stage-valid registers s1_v and s2_v.
  - out_valid = s2_v.
  - Stage 2 loads when ~s2_v | out_ready.
  - Stage 1 loads when ~s1_v | stage-2 load.
  - in_ready = stage-1 load enable (combinational from out_ready and valids).
  - Capacity is 2 transactions.
- While out_valid=1 and out_ready=0, every output holds stable until the handshake completes.
- A stage whose valid is clear loads no data (no X propagation into held outputs).
- Simultaneous accept at input and output in the same cycle is legal. The pipeline advances by one with no bubble.
- Reset (asynchronous, any cycle including mid-transaction):
  - s1_v=0, s2_v=0, out_valid=0.
  - All data outputs and flags clear to 0.
  - In-flight transactions are discarded.
  - in_ready=1 from the first cycle after deassertion.

## Test plan
- Normal: sig_width=23, ex_width=8, mant_mult=0x900000000000, exp_sub=127, sign 0, RNE → after 2 cycles out_exp=128, out_mant=0x100000, all flags 0 (2.25).
- Ties:
  - MSB clear, mant lsb=0, g=1, s=0, RNE → mant unchanged, inexact=1.
  - Same with lsb=1 → mant+1.
  - mant all ones with round-up → mant 0, exp+1.
- Directed modes: g=0, s=1, sign=1:
  - RUP → no increment.
  - RDN → increment.
  - RTZ → no increment.
  - All three → inexact=1.
- Overflow and underflow:
  - exp_sub=254, MSB set, RNE → exp 0xFF, mant 0, overflow=1.
  - Same with RTZ → exp 0xFE, mant 0x7FFFFF.
  - exp_sub=0, MSB clear → exp 0, mant 0, underflow=1.
- Back-pressure: out_ready=0 while pushing 4 back-to-back inputs → exactly 2 accepted, in_ready low from cycle 3. Raise out_ready → results drain in order, with the remaining inputs accepted one per cycle.
- Reset mid-stream with 2 in flight → out_valid=0 and outputs 0 immediately; nothing emitted after release; next input appears 2 cycles after acceptance.

Source files
------------

// File: rtl/normalize_round_mult_pipe.sv
// Normalise (0/1 shift) and round the raw significand product; 2-cycle latency, 2-entry capacity.
// Valid/ready on both sides; a stalled output holds every field stable until taken.
module normalize_round_mult_pipe #(
    parameter int sig_width = 23,
    parameter int ex_width  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic                      in_zero,
    input  logic [2*sig_width+1:0]    mant_mult,
    input  logic [ex_width+1:0]       exp_sub,
    input  logic [1:0]                rnd_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sign,
    output logic [ex_width-1:0]       out_exp,
    output logic [sig_width-1:0]      out_mant,
    output logic                      out_overflow,
    output logic                      out_underflow,
    output logic                      out_inexact
);

    localparam int EW = ex_width + 2;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RUP = 2'b10;
    localparam logic [1:0] RDN = 2'b11;

    localparam logic signed [EW-1:0] EXP_OVF    = EW'((1 << ex_width) - 1);
    localparam logic [ex_width-1:0]  EXP_INF    = '1;
    localparam logic [ex_width-1:0]  EXP_MAXFIN = ex_width'((1 << ex_width) - 2);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_v;
    logic s2_v;
    logic s1_load;
    logic s2_load;

    assign s2_load   = ~s2_v | out_ready;
    assign s1_load   = ~s1_v | s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_v;

    // ------------------------------------------------------------------
    // Stage 1: normalise
    // ------------------------------------------------------------------
    logic [EW-1:0]        n_exp;
    logic [sig_width-1:0] n_mant;
    logic                 n_g;
    logic                 n_s;

    always_comb begin
        n_exp  = exp_sub;
        n_mant = mant_mult[2*sig_width-1 -: sig_width];
        n_g    = mant_mult[sig_width-1];
        n_s    = |mant_mult[sig_width-2:0];
        if (mant_mult[2*sig_width+1]) begin
            n_exp  = exp_sub + EW'(1);
            n_mant = mant_mult[2*sig_width -: sig_width];
            n_g    = mant_mult[sig_width];
            n_s    = |mant_mult[sig_width-1:0];
        end
    end

    logic                 s1_sign;
    logic                 s1_zero;
    logic [1:0]           s1_rnd;
    logic [EW-1:0]        s1_exp;
    logic [sig_width-1:0] s1_mant;
    logic                 s1_g;
    logic                 s1_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_rnd  <= 2'b00;
            s1_exp  <= '0;
            s1_mant <= '0;
            s1_g    <= 1'b0;
            s1_s    <= 1'b0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            // Data only moves with a real transaction so idle inputs never leak in.
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_zero <= in_zero;
                s1_rnd  <= rnd_mode;
                s1_exp  <= n_exp;
                s1_mant <= n_mant;
                s1_g    <= n_g;
                s1_s    <= n_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round and resolve range
    // ------------------------------------------------------------------
    logic                 rnd_inc;
    logic                 rnd_carry;
    logic [sig_width-1:0] mant_r;
    logic [EW-1:0]        exp_r;
    logic                 is_ovf;
    logic                 is_unf;
    logic                 ovf_to_inf;

    always_comb begin
        rnd_inc = 1'b0;
        case (s1_rnd)
            RNE:     rnd_inc = s1_g & (s1_s | s1_mant[0]);
            RTZ:     rnd_inc = 1'b0;
            RUP:     rnd_inc = (s1_g | s1_s) & ~s1_sign;
            RDN:     rnd_inc = (s1_g | s1_s) & s1_sign;
            default: rnd_inc = 1'b0;
        endcase
    end

    // A carry out of the stored mantissa leaves it zero with the hidden bit moved up one.
    assign {rnd_carry, mant_r} = {1'b0, s1_mant} + {{sig_width{1'b0}}, rnd_inc};
    assign exp_r = s1_exp + EW'(rnd_carry);

    assign is_ovf     = $signed(exp_r) >= EXP_OVF;
    assign is_unf     = exp_r[EW-1] | (exp_r == '0);
    assign ovf_to_inf = (s1_rnd == RNE) |
                        ((s1_rnd == RUP) & ~s1_sign) |
                        ((s1_rnd == RDN) & s1_sign);

    logic [ex_width-1:0]  r_exp;
    logic [sig_width-1:0] r_mant;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_inx;

    always_comb begin
        r_exp  = exp_r[ex_width-1:0];
        r_mant = mant_r;
        r_ovf  = 1'b0;
        r_unf  = 1'b0;
        r_inx  = s1_g | s1_s;
        if (s1_zero) begin
            r_exp  = '0;
            r_mant = '0;
            r_inx  = 1'b0;
        end else if (is_ovf) begin
            r_exp  = ovf_to_inf ? EXP_INF : EXP_MAXFIN;
            r_mant = ovf_to_inf ? '0 : '1;
            r_ovf  = 1'b1;
            r_inx  = 1'b1;
        end else if (is_unf) begin
            // Flush to signed zero; subnormals are not produced.
            r_exp  = '0;
            r_mant = '0;
            r_unf  = 1'b1;
            r_inx  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v          <= 1'b0;
            out_sign      <= 1'b0;
            out_exp       <= '0;
            out_mant      <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_sign      <= s1_sign;
                out_exp       <= r_exp;
                out_mant      <= r_mant;
                out_overflow  <= r_ovf;
                out_underflow <= r_unf;
                out_inexact   <= r_inx;
            end
        end
    end

endmodule
